ex_mdu: RTL and testbench

- Parametrised multi-cycle multiply/divide execute unit (RV32M: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle integer ALU in the EX stage and is selected by the decoder for OP-type instructions with funct7 = 0000001.
- Holds the pipeline with a stall signal while busy.
- Presents one register-writeback beat when the result is ready.

---
 rtl/ex_mdu.sv | 192 +++++++++++++++++++
 tb/tb_ex_mdu.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// ex_mdu: RV32M multiply/divide execute unit.
// Pipelined multiplier plus radix-2 restoring divider behind one FSM.
module ex_mdu #(
   parameter int XLEN       = 32,
   parameter int MUL_PIPE   = 1,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            funct3_i,
   input  logic [XLEN-1:0]       rs1_data_i,
   input  logic [XLEN-1:0]       rs2_data_i,
   input  logic [REG_ADDR_W-1:0] wreg_addr_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic                  wreg_en_o,
   output logic [REG_ADDR_W-1:0] wreg_addr_o,
   output logic [XLEN-1:0]       wreg_data_o
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [1:0]            r_op;
   logic [CW-1:0]         r_cnt;
   logic [XLEN-1:0]       r_rem;
   logic [XLEN-1:0]       r_quo;
   logic [XLEN-1:0]       r_dvs;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic [2*XLEN-1:0]     r_prod [MUL_PIPE];
   logic                  r_done;
   logic [REG_ADDR_W-1:0] r_waddr;
   logic [XLEN-1:0]       r_wdata;

   logic                  w_accept;
   logic                  w_a_sgn;
   logic                  w_b_sgn;
   logic [2*XLEN-1:0]     w_ax;
   logic [2*XLEN-1:0]     w_bx;
   logic [2*XLEN-1:0]     w_prod;
   logic                  w_dsgn;
   logic                  w_a_neg;
   logic                  w_b_neg;
   logic [XLEN-1:0]       w_a_mag;
   logic [XLEN-1:0]       w_b_mag;
   logic                  w_b_zero;
   logic                  w_ovf;
   logic                  w_special;
   logic [XLEN-1:0]       w_spec_res;
   logic [XLEN:0]         w_trial;
   logic [XLEN:0]         w_diff;
   logic                  w_ge;
   logic [XLEN-1:0]       w_rem_n;
   logic [XLEN-1:0]       w_quo_n;
   logic [XLEN-1:0]       w_div_res;
   logic [XLEN-1:0]       w_mul_res;

   assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;

   // Operands sign/zero extended to the full product width; the low
   // 2*XLEN bits of the product are exact for every sign combination.
   assign w_a_sgn = (funct3_i[1:0] != 2'b11);
   assign w_b_sgn = !funct3_i[1];
   assign w_ax    = {{XLEN{w_a_sgn & rs1_data_i[XLEN-1]}}, rs1_data_i};
   assign w_bx    = {{XLEN{w_b_sgn & rs2_data_i[XLEN-1]}}, rs2_data_i};
   assign w_prod  = w_ax * w_bx;

   assign w_dsgn   = !funct3_i[0];
   assign w_a_neg  = w_dsgn & rs1_data_i[XLEN-1];
   assign w_b_neg  = w_dsgn & rs2_data_i[XLEN-1];
   assign w_a_mag  = w_a_neg ? -rs1_data_i : rs1_data_i;
   assign w_b_mag  = w_b_neg ? -rs2_data_i : rs2_data_i;
   assign w_b_zero = (rs2_data_i == '0);
   assign w_ovf    = w_dsgn && (rs1_data_i == MIN_NEG) && (&rs2_data_i);
   assign w_special = funct3_i[2] && (w_b_zero || w_ovf);

   assign w_spec_res = w_b_zero ? (funct3_i[1] ? rs1_data_i : '1)
                                : (funct3_i[1] ? '0 : rs1_data_i);

   assign w_trial = {r_rem, r_quo[XLEN-1]};
   assign w_diff  = w_trial - {1'b0, r_dvs};
   assign w_ge    = !w_diff[XLEN];
   assign w_rem_n = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
   assign w_quo_n = {r_quo[XLEN-2:0], w_ge};

   assign w_div_res = r_op[1] ? (r_neg_r ? -w_rem_n : w_rem_n)
                              : (r_neg_q ? -w_quo_n : w_quo_n);

   assign w_mul_res = (r_op == 2'b00) ? r_prod[MUL_PIPE-1][XLEN-1:0]
                                      : r_prod[MUL_PIPE-1][2*XLEN-1:XLEN];

   assign stall_o     = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
   assign done_o      = r_done;
   assign wreg_en_o   = r_done;
   assign wreg_addr_o = r_waddr;
   assign wreg_data_o = r_wdata;

   // Product pipeline: stage 0 loads at accept, later stages shift in MUL.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MUL_PIPE; i++) r_prod[i] <= '0;
      end else begin
         if (w_accept) r_prod[0] <= w_prod;
         if (r_state == S_MUL) begin
            for (int i = 1; i < MUL_PIPE; i++) r_prod[i] <= r_prod[i-1];
         end
      end
   end

   // Control FSM with registered writeback outputs and divider datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_done  <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op    <= funct3_i[1:0];
                  r_waddr <= wreg_addr_i;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_rem   <= '0;
                  r_quo   <= w_a_mag;
                  r_dvs   <= w_b_mag;
                  if (!funct3_i[2]) begin
                     r_cnt   <= CW'(MUL_PIPE - 1);
                     r_state <= S_MUL;
                  end else if (w_special) begin
                     r_wdata <= w_spec_res;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt   <= CW'(XLEN - 1);
                     r_state <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == '0) begin
                  r_wdata <= w_mul_res;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DIV: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem <= w_rem_n;
                  r_quo <= w_quo_n;
                  if (r_cnt == '0) begin
                     r_wdata <= w_div_res;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: scoreboard bench for the multiply/divide unit.
// Expected results are queued at issue and matched against done beats.
module tb_ex_mdu;

   localparam int XLEN = 32;
   localparam int MUL_PIPE = 1;
   localparam int RAW = 5;

   typedef struct {
      logic [RAW-1:0]  addr;
      logic [XLEN-1:0] data;
      int              acc;
      int              lat;
   } exp_t;

   typedef struct {
      logic [RAW-1:0]  addr;
      logic [XLEN-1:0] data;
      logic            wen;
      int              cyc;
   } res_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic [RAW-1:0]  wreg_addr_i;
   logic            flush_i;
   logic            stall_o;
   logic            done_o;
   logic            wreg_en_o;
   logic [RAW-1:0]  wreg_addr_o;
   logic [XLEN-1:0] wreg_data_o;

   exp_t exp_q[$];
   res_t res_q[$];
   int   cyc = 0;
   int   ndone = 0;
   int   pass = 0;
   int   total = 0;

   ex_mdu #(
      .XLEN(XLEN),
      .MUL_PIPE(MUL_PIPE),
      .REG_ADDR_W(RAW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_i(start_i),
      .funct3_i(funct3_i),
      .rs1_data_i(rs1_data_i),
      .rs2_data_i(rs2_data_i),
      .wreg_addr_i(wreg_addr_i),
      .flush_i(flush_i),
      .stall_o(stall_o),
      .done_o(done_o),
      .wreg_en_o(wreg_en_o),
      .wreg_addr_o(wreg_addr_o),
      .wreg_data_o(wreg_data_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_o) begin
         res_q.push_back('{wreg_addr_o, wreg_data_o, wreg_en_o, cyc});
         ndone++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [XLEN-1:0] model(input logic [2:0] f,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] p;
      logic ovf;
      sa = 64'(signed'(a));
      sb = 64'(signed'(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p = '0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a
                      : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0
                      : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f,
                                 input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
      if (!f[2]) return MUL_PIPE + 1;
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Waits for the unit to be idle, drives one request for one edge and
   // queues its expected beat. Returns #1 after the accept edge (cycle 1).
   task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [RAW-1:0] rd);
      int t;
      t = 0;
      @(negedge clk);
      while ((stall_o || done_o) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         total++;
         $display("FAIL issue_wait: stall_o=%b required 0", stall_o);
      end
      start_i = 1'b1;
      funct3_i = f;
      rs1_data_i = a;
      rs2_data_i = b;
      wreg_addr_i = rd;
      exp_q.push_back('{rd, model(f, a, b), cyc, lat_of(f, a, b)});
      @(posedge clk);
      #1 start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_i = 1'b0;
      flush_i = 1'b0;
      funct3_i = '0;
      rs1_data_i = '0;
      rs2_data_i = '0;
      wreg_addr_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({stall_o, done_o, wreg_en_o} !== 3'b000)
         $display("FAIL reset_ctl: got %b required 000",
                  {stall_o, done_o, wreg_en_o});
      else pass++;
      total++;
      if (wreg_addr_o !== '0)
         $display("FAIL reset_addr: got %h required 0", wreg_addr_o);
      else pass++;
      total++;
      if (wreg_data_o !== '0)
         $display("FAIL reset_data: got %h required 0", wreg_data_o);
      else pass++;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({stall_o, done_o} !== 2'b00)
         $display("FAIL reset_idle: got %b required 00", {stall_o, done_o});
      else pass++;
   endtask

   task automatic test_mul();
      res_t a;
      exp_t e;
      int t;
      issue(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd1);
      issue(3'd1, 32'h7, 32'hFFFF_FFFD, 5'd2);
      issue(3'd3, 32'h7, 32'hFFFF_FFFD, 5'd3);
      issue(3'd2, 32'h8000_0001, 32'h8000_0000, 5'd4);
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (res_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
         total++;
         if (res_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL mul_%0d: no result beat", k);
         else begin
            a = res_q.pop_front();
            e = exp_q.pop_front();
            if ({a.data, a.addr, a.wen, a.cyc - e.acc} !==
                {e.data, e.addr, 1'b1, e.lat})
               $display("FAIL mul_%0d: got d=%h a=%0d en=%b lat=%0d required d=%h a=%0d en=1 lat=%0d",
                        k, a.data, a.addr, a.wen, a.cyc - e.acc, e.data, e.addr, e.lat);
            else pass++;
         end
      end
   endtask

   task automatic test_div();
      res_t a;
      exp_t e;
      int t;
      issue(3'd4, 32'hFFFF_FFEC, 32'h3, 5'd5);
      issue(3'd6, 32'hFFFF_FFEC, 32'h3, 5'd6);
      issue(3'd5, 32'hFFFF_FFEC, 32'h3, 5'd7);
      issue(3'd7, 32'hDEAD_BEEF, 32'h0001_2345, 5'd8);
      issue(3'd6, 32'h0000_0014, 32'hFFFF_FFFD, 5'd9);
      for (int k = 0; k < 5; k++) begin
         t = 0;
         while (res_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
         total++;
         if (res_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL div_%0d: no result beat", k);
         else begin
            a = res_q.pop_front();
            e = exp_q.pop_front();
            if ({a.data, a.addr, a.wen, a.cyc - e.acc} !==
                {e.data, e.addr, 1'b1, e.lat})
               $display("FAIL div_%0d: got d=%h a=%0d en=%b lat=%0d required d=%h a=%0d en=1 lat=%0d",
                        k, a.data, a.addr, a.wen, a.cyc - e.acc, e.data, e.addr, e.lat);
            else pass++;
         end
      end
   endtask

   task automatic test_special();
      res_t a;
      exp_t e;
      int t;
      issue(3'd5, 32'h0000_1234, 32'h0, 5'd10);
      issue(3'd7, 32'h0000_1234, 32'h0, 5'd11);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
      issue(3'd4, 32'hFFFF_FF00, 32'h0, 5'd14);
      for (int k = 0; k < 5; k++) begin
         t = 0;
         while (res_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
         total++;
         if (res_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL special_%0d: no result beat", k);
         else begin
            a = res_q.pop_front();
            e = exp_q.pop_front();
            if ({a.data, a.addr, a.wen, a.cyc - e.acc} !==
                {e.data, e.addr, 1'b1, e.lat})
               $display("FAIL special_%0d: got d=%h a=%0d en=%b lat=%0d required d=%h a=%0d en=1 lat=%0d",
                        k, a.data, a.addr, a.wen, a.cyc - e.acc, e.data, e.addr, e.lat);
            else pass++;
         end
      end
   endtask

   task automatic test_flush();
      res_t a;
      exp_t e;
      int t;
      int n0;
      n0 = ndone;
      issue(3'd4, 32'hFFFF_FFEC, 32'h3, 5'd15);
      void'(exp_q.pop_back());
      repeat (9) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0)
         $display("FAIL flush_stall: got %b required 0", stall_o);
      else pass++;
      @(posedge clk);
      issue(3'd0, 32'h0000_0011, 32'h0000_0003, 5'd16);
      t = 0;
      while (res_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
      total++;
      if (res_q.size() == 0 || exp_q.size() == 0)
         $display("FAIL flush_mul: no result beat");
      else begin
         a = res_q.pop_front();
         e = exp_q.pop_front();
         if ({a.data, a.addr, a.cyc - e.acc} !== {e.data, e.addr, e.lat})
            $display("FAIL flush_mul: got d=%h a=%0d lat=%0d required d=%h a=%0d lat=%0d",
                     a.data, a.addr, a.cyc - e.acc, e.data, e.addr, e.lat);
         else pass++;
      end
      total++;
      if (ndone - n0 !== 1)
         $display("FAIL flush_beats: got %0d required 1", ndone - n0);
      else pass++;
      @(negedge clk);
      n0 = ndone;
      start_i = 1'b1;
      flush_i = 1'b1;
      funct3_i = 3'd0;
      #1;
      total++;
      if (stall_o !== 1'b0)
         $display("FAIL flush_idle_stall: got %b required 0", stall_o);
      else pass++;
      @(posedge clk);
      #1 start_i = 1'b0;
      flush_i = 1'b0;
      repeat (8) @(negedge clk);
      total++;
      if (ndone - n0 !== 0)
         $display("FAIL flush_idle_beats: got %0d required 0", ndone - n0);
      else pass++;
   endtask

   task automatic test_reset_mid();
      int n0;
      n0 = ndone;
      issue(3'd5, 32'h0000_0064, 32'h7, 5'd17);
      void'(exp_q.pop_back());
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if ({stall_o, done_o, wreg_en_o} !== 3'b000)
         $display("FAIL rstmid_ctl: got %b required 000",
                  {stall_o, done_o, wreg_en_o});
      else pass++;
      total++;
      if ({wreg_addr_o, wreg_data_o} !== '0)
         $display("FAIL rstmid_wb: got a=%0d d=%h required 0",
                  wreg_addr_o, wreg_data_o);
      else pass++;
      repeat (40) @(negedge clk);
      total++;
      if (ndone - n0 !== 0)
         $display("FAIL rstmid_beats: got %0d required 0", ndone - n0);
      else pass++;
   endtask

   task automatic test_busy_start();
      res_t a;
      exp_t e;
      int t;
      int n0;
      n0 = ndone;
      issue(3'd4, 32'h0000_03E8, 32'hFFFF_FFF9, 5'd18);
      repeat (3) @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         #1 start_i = k[0];
         funct3_i = 3'd0;
         wreg_addr_i = 5'd30;
         @(posedge clk);
      end
      #1 start_i = 1'b0;
      t = 0;
      while (res_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
      total++;
      if (res_q.size() == 0 || exp_q.size() == 0)
         $display("FAIL busy_result: no result beat");
      else begin
         a = res_q.pop_front();
         e = exp_q.pop_front();
         if ({a.data, a.addr, a.cyc - e.acc} !== {e.data, e.addr, e.lat})
            $display("FAIL busy_result: got d=%h a=%0d lat=%0d required d=%h a=%0d lat=%0d",
                     a.data, a.addr, a.cyc - e.acc, e.data, e.addr, e.lat);
         else pass++;
      end
      repeat (40) @(negedge clk);
      total++;
      if (ndone - n0 !== 1)
         $display("FAIL busy_beats: got %0d required 1", ndone - n0);
      else pass++;
   endtask

   task automatic test_back_to_back();
      res_t a;
      exp_t e;
      int t;
      issue(3'd5, 32'd100, 32'd7, 5'd20);
      start_i = 1'b1;
      funct3_i = 3'd2;
      rs1_data_i = 32'hFFFF_FFFF;
      rs2_data_i = 32'h2;
      wreg_addr_i = 5'd21;
      t = 0;
      @(negedge clk);
      while (!done_o && t < 100) begin @(negedge clk); t++; end
      total++;
      if (done_o !== 1'b1 || stall_o !== 1'b0)
         $display("FAIL b2b_done_stall: got done=%b stall=%b required 1 0",
                  done_o, stall_o);
      else pass++;
      @(negedge clk);
      exp_q.push_back('{5'd21, model(3'd2, 32'hFFFF_FFFF, 32'h2), cyc,
                        lat_of(3'd2, 32'hFFFF_FFFF, 32'h2)});
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         t = 0;
         while (res_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
         total++;
         if (res_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL b2b_%0d: no result beat", k);
         else begin
            a = res_q.pop_front();
            e = exp_q.pop_front();
            if ({a.data, a.addr, a.wen, a.cyc - e.acc} !==
                {e.data, e.addr, 1'b1, e.lat})
               $display("FAIL b2b_%0d: got d=%h a=%0d en=%b lat=%0d required d=%h a=%0d en=1 lat=%0d",
                        k, a.data, a.addr, a.wen, a.cyc - e.acc, e.data, e.addr, e.lat);
            else pass++;
         end
      end
      repeat (5) @(negedge clk);
      total++;
      if (res_q.size() != 0)
         $display("FAIL b2b_extra: got %0d beats required 0", res_q.size());
      else pass++;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_reset_mid();
      test_busy_start();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
